// File: rtl/y86_fetch_unit_if.sv
// Fetch-unit bus bundle: byte-wide instruction memory port plus the
// instruction valid/ready handshake toward decode.
interface y86_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic              mem_valid;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [31:0]       valC;
  logic [ADDR_W-1:0] valP;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output mem_addr, mem_rd,
    input  mem_data, mem_valid,
    output icode, ifun, rA, rB, valC, valP, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  mem_addr, mem_rd,
    output mem_data, mem_valid,
    input  icode, ifun, rA, rB, valC, valP, instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/y86_fetch_unit.sv
// y86 fetch/parse stage: one byte per transfer, assembles and presents instructions.
// Optional accepted-instruction counter enabled by defining Y86_FETCH_STATS_EN.
module y86_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  y86_fetch_unit_if.master  bus,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_new,
  output logic              halted,
  output logic              instr_err,
  output logic [31:0]       instr_count
);

  typedef enum logic [2:0] {
    S_FETCH_OP,
    S_FETCH_REG,
    S_FETCH_C,
    S_PRESENT,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        icode_q, ifun_q, ra_q, rb_q;
  logic [31:0]       valc_q;
  logic [1:0]        cnt;
  logic              mem_rd, instr_valid, xfer, redirect;
  logic [3:0]        op_icode;

  function automatic logic has_reg(input logic [3:0] ic);
    return ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
  endfunction

  function automatic logic has_const(input logic [3:0] ic);
    return ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
  endfunction

  assign op_icode = bus.mem_data[7:4];
  assign xfer     = mem_rd && bus.mem_valid;
  assign redirect = pc_load && (state != S_HALTED);

  // NOTE: reset is sampled on the clock edge only, and all state uses <= so
  // every register sees pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FETCH_OP;
    else          state <= state_nxt;
  end

  // NOTE: every comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = S_FETCH_OP;
    end else begin
      unique case (state)
        S_FETCH_OP:
          if (xfer) begin
            if (op_icode > 4'hB)        state_nxt = S_ERROR;
            else if (has_reg(op_icode)) state_nxt = S_FETCH_REG;
            else if (has_const(op_icode)) state_nxt = S_FETCH_C;
            else                        state_nxt = S_PRESENT;
          end
        S_FETCH_REG:
          if (xfer) state_nxt = has_const(icode_q) ? S_FETCH_C : S_PRESENT;
        S_FETCH_C:
          if (xfer && cnt == 2'd3) state_nxt = S_PRESENT;
        S_PRESENT:
          if (bus.instr_ready) state_nxt = (icode_q == 4'h0) ? S_HALTED : S_FETCH_OP;
        default: ;
      endcase
    end
  end

  // Read request is suppressed while reset is held so memory sees no access.
  always_comb begin
    mem_rd      = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    instr_err   = 1'b0;
    unique case (state)
      S_FETCH_OP, S_FETCH_REG, S_FETCH_C: mem_rd = reset_n;
      S_PRESENT: instr_valid = 1'b1;
      S_HALTED:  halted      = 1'b1;
      S_ERROR:   instr_err   = 1'b1;
      default: ;
    endcase
  end

  // Field assembly; a redirect drops any partially gathered operands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc      <= START_ADDR;
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= '0;
      cnt     <= '0;
    end else if (redirect) begin
      pc     <= pc_new;
      ra_q   <= 4'hF;
      rb_q   <= 4'hF;
      valc_q <= '0;
      cnt    <= '0;
    end else if (xfer) begin
      pc <= pc + ADDR_W'(1);
      unique case (state)
        S_FETCH_OP: begin
          icode_q <= bus.mem_data[7:4];
          ifun_q  <= bus.mem_data[3:0];
          ra_q    <= 4'hF;
          rb_q    <= 4'hF;
          valc_q  <= '0;
          cnt     <= '0;
        end
        S_FETCH_REG: begin
          ra_q <= bus.mem_data[7:4];
          rb_q <= bus.mem_data[3:0];
        end
        S_FETCH_C: begin
          valc_q[{cnt, 3'b000} +: 8] <= bus.mem_data;
          cnt                        <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr    = pc;
  assign bus.mem_rd      = mem_rd;
  assign bus.icode       = icode_q;
  assign bus.ifun        = ifun_q;
  assign bus.rA          = ra_q;
  assign bus.rB          = rb_q;
  assign bus.valC        = valc_q;
  assign bus.valP        = pc;
  assign bus.instr_valid = instr_valid;

`ifdef Y86_FETCH_STATS_EN
  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n)                          count_q <= '0;
    else if (instr_valid && bus.instr_ready) count_q <= count_q + 32'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Self-checking bench for y86_fetch_unit: directed scenarios plus a randomized
// program run against a byte-level reference decoder.
module tb_y86_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        pc_load;
  logic [31:0] pc_new;
  logic        halted;
  logic        instr_err;
  logic [31:0] instr_count;

  y86_fetch_unit_if #(.ADDR_W(32)) bus ();

  y86_fetch_unit #(.ADDR_W(32), .START_ADDR(32'h0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .pc_load     (pc_load),
    .pc_new      (pc_new),
    .halted      (halted),
    .instr_err   (instr_err),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] valc;
    int          len;
  } instr_t;

  int          total;
  int          bad;
  logic [7:0]  mem [bit [31:0]];
`ifdef Y86_FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h10;
  endfunction

  function automatic int ref_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 5;
      4'h3, 4'h4, 4'h5:       return 6;
      default:                return 0;
    endcase
  endfunction

  // Reference decode straight from memory bytes at address a.
  function automatic instr_t ref_decode(input logic [31:0] a);
    instr_t     d;
    logic [7:0] b;
    int         off;
    b       = rd(a);
    d.icode = b[7:4];
    d.ifun  = b[3:0];
    d.ra    = 4'hF;
    d.rb    = 4'hF;
    d.valc  = 32'h0;
    d.len   = ref_len(d.icode);
    if (d.len == 2 || d.len == 6) begin
      b    = rd(a + 32'd1);
      d.ra = b[7:4];
      d.rb = b[3:0];
    end
    if (d.len >= 5) begin
      off = d.len - 4;
      for (int k = 0; k < 4; k++)
        d.valc = d.valc + (32'(rd(a + 32'(off + k))) << (8 * k));
    end
    return d;
  endfunction

  task automatic poke_seq(input logic [31:0] a, input logic [47:0] v, input int n);
    for (int i = 0; i < n; i++) mem[a + 32'(i)] = v[8 * (n - 1 - i) +: 8];
  endtask

  // Drive inputs for the next rising edge, then wait for the falling edge.
  task automatic step(input bit v, input bit r, input bit pl, input logic [31:0] pn);
    logic [31:0] prev_addr;
    logic        prev_rd;
    prev_addr       = bus.mem_addr;
    prev_rd         = bus.mem_rd;
    bus.mem_valid   = v;
    bus.mem_data    = rd(bus.mem_addr);
    bus.instr_ready = r;
    pc_load         = pl;
    pc_new          = pn;
    @(negedge clk);
    if (reset_n && prev_rd && !v && !pl) check("addr_hold", bus.mem_addr, prev_addr);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
    check("rst_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_icode", 32'(bus.icode), 32'h0);
    check("rst_ifun", 32'(bus.ifun), 32'h0);
    check("rst_ra", 32'(bus.rA), 32'hF);
    check("rst_rb", 32'(bus.rB), 32'hF);
    check("rst_valc", bus.valC, 32'h0);
    check("rst_valp", bus.valP, 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_err", 32'(instr_err), 32'h0);
    check("rst_count", instr_count, 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic run_until_valid(input int budget, input bit alt);
    int n;
    n = 0;
    while (!bus.instr_valid && n < budget) begin
      step(alt ? n[0] : 1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    check("wait_valid", 32'(bus.instr_valid), 32'h1);
  endtask

  task automatic expect_instr(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [31:0] vc, input logic [31:0] vp);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'h1);
    check({tag, "_icode"}, 32'(bus.icode), 32'(ic));
    check({tag, "_ifun"}, 32'(bus.ifun), 32'(fn));
    check({tag, "_ra"}, 32'(bus.rA), 32'(ra));
    check({tag, "_rb"}, 32'(bus.rB), 32'(rb));
    check({tag, "_valc"}, bus.valC, vc);
    check({tag, "_valp"}, bus.valP, vp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t      cur;
    logic [31:0] exp_pc, a, pn;
    logic [31:0] bnd [$];
    int          acc, cyc, n;
    bit          done, ov, v, r, pl;
    logic [3:0]  ic;

    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    pc_load = 1'b0;
    pc_new  = 32'h0;
    bus.mem_valid   = 1'b0;
    bus.mem_data    = 8'h0;
    bus.instr_ready = 1'b0;

    // irmovl with 6-cycle latency and little-endian constant
    mem.delete();
    poke_seq(32'h0, 48'h30F078563412, 6);
    do_reset();
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("irmovl_not_early", 32'(bus.instr_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_instr("irmovl", 4'h3, 4'h0, 4'hF, 4'h0, 32'h12345678, 32'h6);

    // addl held under back-pressure, then rrmovl from address 2
    mem.delete();
    poke_seq(32'h0, 48'h60122003, 4);
    do_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_instr("addl", 4'h6, 4'h0, 4'h1, 4'h2, 32'h0, 32'h2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("stall_mem_rd", 32'(bus.mem_rd), 32'h0);
      expect_instr("stall", 4'h6, 4'h0, 4'h1, 4'h2, 32'h0, 32'h2);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("after_accept_valid", 32'(bus.instr_valid), 32'h0);
    check("after_accept_addr", bus.mem_addr, 32'h2);
    check("after_accept_rd", 32'(bus.mem_rd), 32'h1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_instr("rrmovl", 4'h2, 4'h0, 4'h0, 4'h3, 32'h0, 32'h4);

    // jXX with gappy memory responses
    mem.delete();
    poke_seq(32'h0, 48'h7000010000, 5);
    do_reset();
    run_until_valid(40, 1'b1);
    expect_instr("jmp", 4'h7, 4'h0, 4'hF, 4'hF, 32'h100, 32'h5);

    // redirect in the middle of an irmovl constant
    mem.delete();
    poke_seq(32'h0, 48'h30F111223344, 6);
    poke_seq(32'h40, 48'h10, 1);
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h40);
    check("redir_valid", 32'(bus.instr_valid), 32'h0);
    check("redir_addr", bus.mem_addr, 32'h40);
    check("redir_rd", 32'(bus.mem_rd), 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_instr("redir_nop", 4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h41);

    // illegal opcode, recovery by redirect, then halt
    mem.delete();
    poke_seq(32'h0, 48'hC0, 1);
    poke_seq(32'h80, 48'h00, 1);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("err_set", 32'(instr_err), 32'h1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("err_sticky", 32'(instr_err), 32'h1);
    check("err_mem_rd", 32'(bus.mem_rd), 32'h0);
    check("err_valid", 32'(bus.instr_valid), 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h80);
    check("err_cleared", 32'(instr_err), 32'h0);
    check("err_redir_addr", bus.mem_addr, 32'h80);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_instr("halt", 4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h81);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("halted_set", 32'(halted), 32'h1);
    check("halted_valid", 32'(bus.instr_valid), 32'h0);
    repeat (3) step(1'b1, 1'b1, 1'b1, 32'h40);
    check("halted_ignores_load", 32'(halted), 32'h1);
    check("halted_mem_rd", 32'(bus.mem_rd), 32'h0);

    // PC wrap at the top of the address space
    mem.delete();
    poke_seq(32'hFFFF_FFFF, 48'h20, 1);
    poke_seq(32'h0, 48'h45, 1);
    do_reset();
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    check("wrap_addr", bus.mem_addr, 32'hFFFF_FFFF);
    run_until_valid(10, 1'b0);
    expect_instr("wrap", 4'h2, 4'h0, 4'h4, 4'h5, 32'h0, 32'h1);

    // five accepted instructions ending in halt
    mem.delete();
    poke_seq(32'h0, 48'h1010101000, 5);
    do_reset();
    n = 0;
    while (!halted && n < 100) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    check("count_halted", 32'(halted), 32'h1);
    check("count_value", instr_count, STATS ? 32'd5 : 32'd0);

    // randomized program with random stalls, back-pressure and redirects
    mem.delete();
    a = 32'h200;
    for (int i = 0; i < 30; i++) begin
      ic = 4'($urandom_range(1, 11));
      bnd.push_back(a);
      mem[a] = {ic, 4'($urandom_range(0, 15))};
      for (int k = 1; k < ref_len(ic); k++) mem[a + 32'(k)] = 8'($urandom_range(0, 255));
      a = a + 32'(ref_len(ic));
    end
    mem[a] = 8'h00;
    do_reset();
    step(1'b1, 1'b0, 1'b1, 32'h200);
    exp_pc = 32'h200;
    acc    = 0;
    cyc    = 0;
    done   = 1'b0;
    while (!done && cyc < 20000) begin
      ov  = bus.instr_valid;
      cur = ref_decode(exp_pc);
      v   = ($urandom_range(0, 9) < 7);
      r   = ($urandom_range(0, 9) < 5);
      pl  = ($urandom_range(0, 99) < 3) && !(ov && cur.icode == 4'h0);
      pn  = bnd[$urandom_range(0, bnd.size() - 1)];
      step(v, r, pl, pn);
      if (ov && r) begin
        acc++;
        if (cur.icode == 4'h0) done = 1'b1;
        exp_pc = exp_pc + 32'(cur.len);
      end
      if (pl) exp_pc = pn;
      if (!done && bus.instr_valid) begin
        cur = ref_decode(exp_pc);
        expect_instr("rnd", cur.icode, cur.ifun, cur.ra, cur.rb, cur.valc,
                     exp_pc + 32'(cur.len));
      end
      cyc++;
    end
    check("rnd_done", 32'(done), 32'h1);
    check("rnd_halted", 32'(halted), 32'h1);
    check("rnd_mem_rd", 32'(bus.mem_rd), 32'h0);
    check("rnd_count", instr_count, STATS ? 32'(acc) : 32'd0);

    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
